// File: rtl/trng_sampler.sv
// trng_sampler: synchronizes a ring-oscillator bit, decimates it, optionally
// von Neumann debiases it, packs words LSB-first and runs a repetition-count test.
//
// state  | meaning
// IDLE   | sampler stopped; partial word, pair bit and RCT count held at zero
// WAIT_A | waiting for a strobe (every bit when VN off, first bit of a pair when on)
// WAIT_B | waiting for the strobe carrying the second bit of a VN pair
module trng_sampler #(
   parameter int WIDTH = 32,
   parameter int DIV_W = 8,
   parameter int RCT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             raw_i,
   input  logic             enable_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             vn_en_i,
   input  logic [RCT_W-1:0] rct_thresh_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             overflow_o,
   output logic             rct_fail_o
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [RCT_W-1:0] RCT_MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync2_q;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               vn_q, vn_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic               a_q, a_d;
   logic [BW-1:0]      bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic               ovf_q, ovf_d;
   logic [RCT_W-1:0]   rct_q, rct_d;
   logic               prev_q, prev_d;
   logic               rctf_q, rctf_d;

   logic               s;
   logic               strobe;
   logic               emit;
   logic               emit_bit;
   logic               word_full;
   logic [WIDTH-1:0]   new_word;
   logic [RCT_W-1:0]   rct_next;
   logic               ovf_set;
   logic               rctf_set;

   assign s = sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         div_q    <= '0;
         vn_q     <= 1'b0;
         cnt_q    <= '0;
         a_q      <= 1'b0;
         bitcnt_q <= '0;
         word_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         rct_q    <= '0;
         prev_q   <= 1'b0;
         rctf_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         vn_q     <= vn_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         bitcnt_q <= bitcnt_d;
         word_q   <= word_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         rct_q    <= rct_d;
         prev_q   <= prev_d;
         rctf_q   <= rctf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      vn_d      = vn_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      bitcnt_d  = bitcnt_q;
      word_d    = word_q;
      data_d    = data_q;
      valid_d   = valid_q;
      rct_d     = rct_q;
      prev_d    = prev_q;
      strobe    = 1'b0;
      emit      = 1'b0;
      emit_bit  = 1'b0;
      word_full = 1'b0;
      new_word  = word_q;
      rct_next  = rct_q;
      ovf_set   = 1'b0;
      rctf_set  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            bitcnt_d = '0;
            word_d   = '0;
            a_d      = 1'b0;
            rct_d    = '0;
            prev_d   = 1'b0;
            if (enable_i) begin
               state_d = WAIT_A;
               div_d   = div_i;
               vn_d    = vn_en_i;
            end
         end
         default: begin
            if (!enable_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               strobe = (cnt_q == div_q);
               cnt_d  = strobe ? '0 : cnt_q + DIV_W'(1);
            end
         end
      endcase

      if (strobe) begin
         if (!vn_q) begin
            emit     = 1'b1;
            emit_bit = s;
         end else if (state_q == WAIT_A) begin
            a_d     = s;
            state_d = WAIT_B;
         end else begin
            emit     = (s != a_q);
            emit_bit = a_q;
            state_d  = WAIT_A;
         end

         // Health test sees raw decimated samples, before debiasing.
         if (rct_q == '0 || s != prev_q)
            rct_next = RCT_MAX & RCT_W'(1);
         else if (rct_q != RCT_MAX)
            rct_next = rct_q + RCT_W'(1);
         rct_d    = rct_next;
         prev_d   = s;
         rctf_set = (rct_thresh_i != '0) && (rct_next == rct_thresh_i);
      end

      if (emit) begin
         new_word[bitcnt_q] = emit_bit;
         if (bitcnt_q == LAST_BIT) begin
            word_full = 1'b1;
            bitcnt_d  = '0;
            word_d    = '0;
         end else begin
            bitcnt_d = bitcnt_q + BW'(1);
            word_d   = new_word;
         end
      end

      if (valid_q && ready_i)
         valid_d = 1'b0;
      if (word_full) begin
         if (!valid_q || ready_i) begin
            data_d  = new_word;
            valid_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end

      if (clr_i)
         rct_d = '0;
      ovf_d  = clr_i ? 1'b0 : (ovf_q | ovf_set);
      rctf_d = clr_i ? 1'b0 : (rctf_q | rctf_set);
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign overflow_o = ovf_q;
   assign rct_fail_o = rctf_q;

endmodule
